// File: rtl/counter_sequencer.sv
// counter_sequencer: commanded WIDTH-bit up-counter with programmable terminal
// count, one-shot or auto-reload operation, and busy/done/tick/err status.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped; q is 0, tc may be reloaded
// RUN   | counting toward tc (wrapping if reload, else heading to DONE)
// PAUSE | counting suspended, q held; PAUSE again resumes
// DONE  | one-shot reached tc; q holds tc, tc may be reloaded
module counter_sequencer #(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_TC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             mode_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic             err,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  state_t           state;
  logic [WIDTH-1:0] tc;
  logic             reload;

  // Every command is accepted in the cycle it is presented.
  assign cmd_ready = 1'b1;

  // Status levels decode directly from the state register.
  assign busy = (state == S_RUN) || (state == S_PAUSE);
  assign done = (state == S_DONE);

  // Sequencer: commands take priority over counting; tick/err are one-edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      q        <= '0;
      tc       <= WIDTH'(DEFAULT_TC);
      reload   <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
      wrap_cnt <= 8'd0;
    end else begin
      tick <= 1'b0;
      err  <= 1'b0;
      if (cmd_valid) begin
        case (cmd_op)
          OP_START: begin
            q        <= '0;
            wrap_cnt <= 8'd0;
            reload   <= mode_reload;
            state    <= S_RUN;
          end
          OP_STOP: begin
            q     <= '0;
            state <= S_IDLE;
          end
          OP_PAUSE: begin
            case (state)
              S_RUN:   state <= S_PAUSE;
              S_PAUSE: state <= S_RUN;
              default: err   <= 1'b1;
            endcase
          end
          OP_LOAD: begin
            // tc is frozen while a count is in progress so the active run
            // always terminates where it was started.
            if ((state == S_IDLE) || (state == S_DONE)) begin
              tc <= cmd_data;
            end else begin
              err <= 1'b1;
            end
          end
          default: err <= 1'b1;
        endcase
      end else if (state == S_RUN) begin
        if (q != tc) begin
          q <= q + WIDTH'(1);
        end else if (reload) begin
          q        <= '0;
          tick     <= 1'b1;
          wrap_cnt <= wrap_cnt + 8'd1;
        end else begin
          state <= S_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed command sequences, a behavioural model
// based on elapsed counting edges, and hand-computed literal checkpoints.
module tb_counter_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic         mode_reload = 1'b0;
  logic [W-1:0] q;
  logic         busy, done, tick, err;
  logic [7:0]   wrap_cnt;

  int tests = 0;
  int fails = 0;

  counter_sequencer #(.WIDTH(W), .DEFAULT_TC(15)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .mode_reload(mode_reload),
    .q(q), .busy(busy), .done(done), .tick(tick), .err(err), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: while a run is active, position is derived from the number of
  // counting edges since START (elapsed) with plain division/modulo.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_st;
  int  m_tc, m_el, m_fixed_q, m_wrap_hold;
  bit  m_rl, m_tick, m_err, model_ok = 0;

  function automatic int m_q();
    if (m_st == M_RUN || m_st == M_PAUSE) return m_rl ? (m_el % (m_tc + 1)) : m_el;
    return m_fixed_q;
  endfunction

  function automatic int m_wraps();
    if (m_st == M_IDLE) return m_wrap_hold;
    return m_rl ? ((m_el / (m_tc + 1)) % 256) : 0;
  endfunction

  always @(posedge clk) begin
    m_tick = 0;
    m_err  = 0;
    if (reset) begin
      m_st = M_IDLE; m_tc = 15; m_el = 0; m_rl = 0; m_fixed_q = 0; m_wrap_hold = 0;
      model_ok = 1;
    end else if (cmd_valid) begin
      case (cmd_op)
        2'b00: begin m_st = M_RUN; m_el = 0; m_rl = mode_reload; end
        2'b01: begin m_wrap_hold = m_wraps(); m_st = M_IDLE; m_fixed_q = 0; end
        2'b10: begin
          if (m_st == M_RUN) m_st = M_PAUSE;
          else if (m_st == M_PAUSE) m_st = M_RUN;
          else m_err = 1;
        end
        default: begin
          if (m_st == M_IDLE || m_st == M_DONE) m_tc = int'(cmd_data);
          else m_err = 1;
        end
      endcase
    end else if (m_st == M_RUN) begin
      if (!m_rl && m_el == m_tc) begin
        m_st = M_DONE;
        m_fixed_q = m_tc;
      end else begin
        m_el++;
        if (m_rl && (m_el % (m_tc + 1)) == 0) m_tick = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("q", int'(q), m_q());
      chk("busy", int'(busy), int'(m_st == M_RUN || m_st == M_PAUSE));
      chk("done", int'(done), int'(m_st == M_DONE));
      chk("tick", int'(tick), int'(m_tick));
      chk("err", int'(err), int'(m_err));
      chk("wrap_cnt", int'(wrap_cnt), m_wraps());
      chk("cmd_ready", int'(cmd_ready), 1);
    end
  end

  // Drive a command at the current negedge for exactly one edge.
  task automatic send(input logic [1:0] op, input int data, input logic rl);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data[W-1:0]; mode_reload = rl;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(wrap_cnt), 0);
    chk("rst_tick_err", int'({tick, err}), 0);

    // One-shot, tc=5
    send(2'b11, 5, 0);
    send(2'b00, 0, 0);
    chk("os_q0", int'(q), 0);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      chk("os_q", int'(q), k);
      chk("os_busy", int'(busy), 1);
    end
    idle(1);
    chk("os_done", int'(done), 1);
    chk("os_busy_end", int'(busy), 0);
    chk("os_qhold", int'(q), 5);
    chk("model_q_done", m_q(), 5);
    idle(1);
    chk("os_qhold2", int'(q), 5);

    // Auto-reload, tc=3
    send(2'b11, 3, 0);
    send(2'b00, 0, 1);
    chk("rl_q0", int'(q), 0);
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      chk("rl_q", int'(q), k % 4);
      chk("rl_tick", int'(tick), int'((k % 4) == 0));
      chk("rl_done", int'(done), 0);
    end
    chk("rl_wrap", int'(wrap_cnt), 3);
    chk("model_wrap", m_wraps(), 3);

    // Pause / resume with tc=9
    send(2'b01, 0, 0);
    chk("stop_wrap_held", int'(wrap_cnt), 3);
    send(2'b11, 9, 0);
    send(2'b00, 0, 0);
    idle(2);
    chk("pz_q_before", int'(q), 2);
    send(2'b10, 0, 0);
    chk("pz_q_paused", int'(q), 2);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("pz_hold", int'(q), 2);
      chk("pz_busy", int'(busy), 1);
    end
    send(2'b10, 0, 0);
    chk("pz_resume_edge", int'(q), 2);
    idle(1);
    chk("pz_q3", int'(q), 3);
    idle(1);
    chk("pz_q4", int'(q), 4);

    // Illegal LOAD_TC while running
    send(2'b11, 7, 0);
    chk("ld_run_err", int'(err), 1);
    chk("ld_run_q", int'(q), 4);
    idle(1);
    chk("ld_run_err_clr", int'(err), 0);
    chk("ld_run_q5", int'(q), 5);
    idle(4);
    chk("ld_run_q9", int'(q), 9);
    chk("ld_run_busy", int'(busy), 1);
    idle(1);
    chk("ld_run_done", int'(done), 1);
    chk("ld_run_qtc", int'(q), 9);

    // Illegal PAUSE in IDLE
    send(2'b01, 0, 0);
    send(2'b10, 0, 0);
    chk("pz_idle_err", int'(err), 1);
    chk("pz_idle_busy", int'(busy), 0);
    idle(1);
    chk("pz_idle_err_clr", int'(err), 0);
    chk("pz_idle_done", int'(done), 0);

    // Reset mid-run with a START presented in the same cycle
    send(2'b11, 15, 0);
    send(2'b00, 0, 0);
    idle(7);
    chk("mr_q7", int'(q), 7);
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; mode_reload = 1'b1;
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    chk("mr_q", int'(q), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    send(2'b00, 0, 0);
    idle(15);
    chk("mr_tc15_q", int'(q), 15);
    chk("mr_tc15_busy", int'(busy), 1);
    idle(1);
    chk("mr_tc15_done", int'(done), 1);

    // tc=0 one-shot, then STOP
    send(2'b11, 0, 0);
    send(2'b00, 0, 0);
    chk("t0_busy", int'(busy), 1);
    chk("t0_q", int'(q), 0);
    idle(1);
    chk("t0_done", int'(done), 1);
    send(2'b01, 0, 0);
    chk("t0_stop_done", int'(done), 0);
    chk("t0_stop_busy", int'(busy), 0);
    chk("t0_stop_q", int'(q), 0);

    // tc=0 reload: tick every cycle
    send(2'b00, 0, 1);
    chk("t0r_tick0", int'(tick), 0);
    idle(1);
    chk("t0r_tick1", int'(tick), 1);
    chk("t0r_wrap1", int'(wrap_cnt), 1);
    idle(1);
    chk("t0r_tick2", int'(tick), 1);
    chk("t0r_wrap2", int'(wrap_cnt), 2);
    chk("t0r_q", int'(q), 0);

    // Command coincident with terminal count (reload, tc=2)
    send(2'b01, 0, 0);
    send(2'b11, 2, 0);
    send(2'b00, 0, 1);
    idle(2);
    chk("cw_at_tc", int'(q), 2);
    send(2'b10, 0, 0);
    chk("cw_pz_q", int'(q), 2);
    chk("cw_pz_tick", int'(tick), 0);
    chk("cw_pz_wrap", int'(wrap_cnt), 0);
    send(2'b10, 0, 0);
    chk("cw_resume_q", int'(q), 2);
    idle(1);
    chk("cw_wrap_q", int'(q), 0);
    chk("cw_wrap_tick", int'(tick), 1);
    chk("cw_wrap_cnt", int'(wrap_cnt), 1);

    // Command coincident with terminal count (one-shot, tc=2)
    send(2'b00, 0, 0);
    idle(2);
    chk("cw_os_at_tc", int'(q), 2);
    send(2'b00, 0, 0);
    chk("cw_os_q", int'(q), 0);
    chk("cw_os_done", int'(done), 0);
    chk("cw_os_busy", int'(busy), 1);
    idle(3);
    chk("cw_os_final", int'(done), 1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
